gb_serial: RTL

Parametrised Game Boy serial link controller that replaces the dummy SB/SC logic with a real shift engine. It owns SB ($FF01) and SC ($FF02), shifts 8 bits per transfer on an internal or an external shift clock, and drives the link pins. It raises a one-cycle serial interrupt pulse that feeds IF bit 3. It sits beside the timer on the CPU bus in the gb top level.

---
 rtl/gb_serial.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/gb_serial.sv
// gb_serial: Game Boy SB/SC serial link shift engine with internal/external clock.
// Optional CGB fast internal clock (SC bit1) is built when SERIAL_FAST_EN is defined.
module gb_serial #(
    parameter int DIV_LOG2    = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_sel_sb,
    input  logic       cpu_sel_sc,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    input  logic       ser_clk_in,
    input  logic       ser_data_in,
    output logic       ser_clk_out,
    output logic       ser_clk_oe,
    output logic       ser_data_out,
    output logic       irq
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [DIV_LOG2-1:0] DIV_ONE = 1;

    state_t                 state_q, state_d;
    logic [7:0]             sb_q, sb_d;
    logic                   sc_start_q, sc_start_d;
    logic                   sc_clksel_q, sc_clksel_d;
    logic [2:0]             bcnt_q, bcnt_d;
    logic [DIV_LOG2-1:0]    div_q, div_d;
    logic                   sample_q, sample_d;
    logic                   irq_q, irq_d;
    logic                   data_out_q, data_out_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    logic [DIV_LOG2-1:0] div_dec;
    logic                half_now;
    logic                half_nxt;
    logic                period_end;
    logic                clk_s;
    logic                dat_s;
    logic                sb_wr;
    logic                sc_wr;
    logic                shift;
    logic                shift_bit;

    assign div_dec = div_q - DIV_ONE;
    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign dat_s   = dat_sync_q[SYNC_STAGES-1];
    assign sb_wr   = cpu_wr & cpu_sel_sb;
    assign sc_wr   = cpu_wr & cpu_sel_sc;

`ifdef SERIAL_FAST_EN
    logic sc_fast_q, sc_fast_d;

    // Fast mode runs the same down-counter but only watches its low bits.
    assign half_now   = sc_fast_q ? div_q[DIV_LOG2-6] : div_q[DIV_LOG2-1];
    assign half_nxt   = sc_fast_q ? div_dec[DIV_LOG2-6] : div_dec[DIV_LOG2-1];
    assign period_end = sc_fast_q ? (div_q[DIV_LOG2-6:0] == '0) : (div_q == '0);
`else
    assign half_now   = div_q[DIV_LOG2-1];
    assign half_nxt   = div_dec[DIV_LOG2-1];
    assign period_end = (div_q == '0);
`endif

    always_comb begin
        cpu_do = 8'hFF;
        if (cpu_sel_sb) begin
            cpu_do = sb_q;
        end else if (cpu_sel_sc) begin
`ifdef SERIAL_FAST_EN
            cpu_do = {sc_start_q, 5'h1F, sc_fast_q, sc_clksel_q};
`else
            cpu_do = {sc_start_q, 6'h3F, sc_clksel_q};
`endif
        end
    end

    assign ser_clk_out  = (state_q == ACTIVE && sc_clksel_q) ? ~half_now : 1'b1;
    assign ser_clk_oe   = sc_clksel_q;
    assign ser_data_out = data_out_q;
    assign irq          = irq_q;

    always_comb begin
        state_d     = state_q;
        sb_d        = sb_q;
        sc_start_d  = sc_start_q;
        sc_clksel_d = sc_clksel_q;
        bcnt_d      = bcnt_q;
        div_d       = div_q;
        sample_d    = sample_q;
        irq_d       = 1'b0;
        shift       = 1'b0;
        shift_bit   = 1'b0;
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ser_clk_in};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], ser_data_in};
        clk_prev_d  = clk_s;
`ifdef SERIAL_FAST_EN
        sc_fast_d   = sc_fast_q;
`endif

        if (state_q == ACTIVE) begin
            if (sc_clksel_q) begin
                div_d     = period_end ? '1 : div_dec;
                shift     = period_end;
                shift_bit = sample_q;
                if (half_now && !half_nxt && !period_end) begin
                    sample_d = dat_s;
                end
            end else begin
                shift     = clk_s & ~clk_prev_q;
                shift_bit = dat_s;
            end
        end

        if (shift) begin
            sb_d   = {sb_q[6:0], shift_bit};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
                state_d    = IDLE;
                sc_start_d = 1'b0;
                irq_d      = 1'b1;
            end
        end

        // A CPU write to SB overrides a coincident shift; bcnt still advances.
        if (sb_wr) begin
            sb_d = cpu_di;
        end

        if (sc_wr) begin
            sc_clksel_d = cpu_di[0];
`ifdef SERIAL_FAST_EN
            sc_fast_d   = cpu_di[1];
`endif
            sc_start_d  = cpu_di[7];
            irq_d       = 1'b0;
            if (cpu_di[7]) begin
                state_d = ACTIVE;
                bcnt_d  = 3'd0;
                div_d   = '1;
            end else begin
                state_d = IDLE;
            end
        end

        data_out_d = sb_d[7];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sb_q        <= 8'h00;
            sc_start_q  <= 1'b0;
            sc_clksel_q <= 1'b0;
            bcnt_q      <= 3'd0;
            div_q       <= '1;
            sample_q    <= 1'b1;
            irq_q       <= 1'b0;
            data_out_q  <= 1'b0;
            clk_sync_q  <= '0;
            dat_sync_q  <= '0;
            clk_prev_q  <= 1'b0;
`ifdef SERIAL_FAST_EN
            sc_fast_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sb_q        <= sb_d;
            sc_start_q  <= sc_start_d;
            sc_clksel_q <= sc_clksel_d;
            bcnt_q      <= bcnt_d;
            div_q       <= div_d;
            sample_q    <= sample_d;
            irq_q       <= irq_d;
            data_out_q  <= data_out_d;
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_prev_q  <= clk_prev_d;
`ifdef SERIAL_FAST_EN
            sc_fast_q   <= sc_fast_d;
`endif
        end
    end

endmodule
